hs_fifo_mc_sfifo: RTL

Multi-channel synchronous FIFO, the parametrised successor to the single-channel sync FIFO. It holds CH_NUM independent FIFOs in one statically partitioned storage array, with one write port and one read port, each steered by a channel index. Optional packet mode makes data readable only once the packet's last beat is written, and optional drop discards an incomplete packet. It sits between a channelised producer (DMA, packet parser) and a per-channel scheduler.

---
 rtl/hs_fifo_mc_sfifo.sv | 139 +++++++++++++
 1 files changed

// File: rtl/hs_fifo_mc_sfifo.sv
// Multi-channel synchronous FIFO: CH_NUM independent FIFOs in one partitioned array,
// one write port and one read port steered by channel index, optional packet commit/drop.
package hs_fifo_mc_sfifo_pkg;
    typedef enum logic {FALSE = 1'b0, TRUE = 1'b1} bool_e;
endpackage

module hs_fifo_mc_sfifo
    import hs_fifo_mc_sfifo_pkg::*;
#(
    parameter type   DATA_TYPE        = logic [15:0],
    parameter int    CH_NUM           = 4,
    parameter int    CH_DEPTH         = 32,
    parameter int    ALMOST_FULL_LVL  = CH_DEPTH,
    parameter int    ALMOST_EMPTY_LVL = 0,
    parameter bool_e EN_PACKET_MODE   = FALSE,
    parameter bool_e EN_DROP_PACKET   = FALSE,
    localparam int   CH_W             = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
    localparam int   CNT_W            = $clog2(CH_DEPTH) + 1
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [CH_W-1:0]           wr_ch,
    input  DATA_TYPE                  wr_data,
    input  logic                      wr_last,
    input  logic                      wr_drop,
    input  logic [CH_W-1:0]           rd_ch,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output DATA_TYPE                  rd_data,
    output logic                      rd_last,
    output logic [CH_NUM*CNT_W-1:0]   ch_count,
    output logic [CH_NUM-1:0]         ch_full,
    output logic [CH_NUM-1:0]         ch_empty,
    output logic [CH_NUM-1:0]         ch_almost_full,
    output logic [CH_NUM-1:0]         ch_almost_empty
);
    localparam int AW = CH_W + CNT_W - 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(CH_DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(ALMOST_FULL_LVL);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(ALMOST_EMPTY_LVL);

    typedef struct packed {
        logic     last;
        DATA_TYPE data;
    } entry_t;

    entry_t mem [2**AW];

    logic [CH_NUM-1:0][CNT_W-1:0] wr_ptr_all;
    logic [CH_NUM-1:0][CNT_W-1:0] rd_ptr_all;
    logic [CH_NUM-1:0]            wr_sel;
    logic [CH_NUM-1:0]            rd_sel;
    logic                         drop_en;
    logic                         wr_fire;
    logic                         rd_fire;
    logic [CNT_W-1:0]             wr_ptr_cur;
    logic [CNT_W-1:0]             rd_ptr_cur;
    logic [AW-1:0]                wr_addr;
    logic [AW-1:0]                rd_addr;
    entry_t                       rd_entry;

    // A drop cycle swallows any beat presented alongside it.
    assign drop_en  = (EN_DROP_PACKET == TRUE) && wr_drop;
    assign wr_ready = |(wr_sel & ~ch_full);
    assign rd_valid = |(rd_sel & ~ch_empty);
    assign wr_fire  = wr_valid && wr_ready && !drop_en;
    assign rd_fire  = rd_valid && rd_ready;

    always_comb begin
        wr_ptr_cur = '0;
        rd_ptr_cur = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (wr_sel[i]) wr_ptr_cur = wr_ptr_all[i];
            if (rd_sel[i]) rd_ptr_cur = rd_ptr_all[i];
        end
    end

    assign wr_addr = {wr_ch, wr_ptr_cur[CNT_W-2:0]};
    assign rd_addr = {rd_ch, rd_ptr_cur[CNT_W-2:0]};

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_addr] <= '{last: wr_last, data: wr_data};
        end
    end

    // Head is read combinationally so the selected channel's data falls through immediately.
    assign rd_entry = mem[rd_addr];
    assign rd_data  = rd_entry.data;
    assign rd_last  = rd_entry.last;

    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
        logic [CNT_W-1:0] wr_ptr_reg;
        logic [CNT_W-1:0] rd_ptr_reg;
        logic [CNT_W-1:0] cmt_ptr_reg;
        logic [CNT_W-1:0] wr_ptr_next;
        logic [CNT_W-1:0] occ;
        logic [CNT_W-1:0] readable;

        assign wr_sel[gi]  = (wr_ch == CH_W'(gi));
        assign rd_sel[gi]  = (rd_ch == CH_W'(gi));
        assign wr_ptr_next = wr_ptr_reg + CNT_W'(1);

        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr_reg  <= '0;
                rd_ptr_reg  <= '0;
                cmt_ptr_reg <= '0;
            end else begin
                if (drop_en && wr_sel[gi]) begin
                    wr_ptr_reg <= cmt_ptr_reg;
                end else if (wr_fire && wr_sel[gi]) begin
                    wr_ptr_reg <= wr_ptr_next;
                    if (wr_last) begin
                        cmt_ptr_reg <= wr_ptr_next;
                    end
                end
                if (rd_fire && rd_sel[gi]) begin
                    rd_ptr_reg <= rd_ptr_reg + CNT_W'(1);
                end
            end
        end

        // Full tracks physical occupancy; everything else tracks what a reader may see.
        assign occ      = wr_ptr_reg - rd_ptr_reg;
        assign readable = (EN_PACKET_MODE == TRUE) ? (cmt_ptr_reg - rd_ptr_reg) : occ;

        assign wr_ptr_all[gi]                 = wr_ptr_reg;
        assign rd_ptr_all[gi]                 = rd_ptr_reg;
        assign ch_count[gi*CNT_W +: CNT_W]    = readable;
        assign ch_empty[gi]                   = (readable == '0);
        assign ch_full[gi]                    = (occ == DEPTH_C);
        assign ch_almost_full[gi]             = (readable >= AF_C);
        assign ch_almost_empty[gi]            = (readable <= AE_C);
    end

endmodule
